// File: rtl/hs_fifo_source.sv
// Handshake responder fed by a FIFO: queued words are served in order,
// one per req/ack exchange, with a deterministic stall input.
module hs_fifo_source #(
   parameter int unsigned           data_width    = 32,
   parameter int unsigned           depth         = 16,
   parameter logic [data_width-1:0] initial_value = '0,
   parameter int unsigned           source_id     = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [data_width-1:0]    push_data,
   input  logic                     stall,
   input  logic                     req,
   output logic                     ack,
   output logic [data_width-1:0]    dout,
   output logic [31:0]              count,
   output logic [$clog2(depth):0]   level,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(depth);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [data_width-1:0] mem [depth];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;

   logic                  pop_c;
   logic                  push_c;
   logic [LVL_W-1:0]      level_nxt_c;

   // Full is judged from the registered level only; a same-cycle pop never frees a slot.
   assign push_ready = (level != LVL_W'(depth));

   always_comb begin
      pop_c       = 1'b0;
      push_c      = 1'b0;
      level_nxt_c = level;

      pop_c  = req & ~ack & ~stall & ~empty;
      push_c = push_valid & push_ready;

      if (push_c && !pop_c) begin
         level_nxt_c = level + LVL_W'(1);
      end else if (pop_c && !push_c) begin
         level_nxt_c = level - LVL_W'(1);
      end
   end

   // Handshake, data and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack    <= 1'b0;
         dout   <= initial_value;
         count  <= 32'd0;
         level  <= '0;
         empty  <= 1'b1;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         ack <= pop_c;
         if (pop_c) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count + 32'd1;
         end
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         level <= level_nxt_c;
         empty <= (level_nxt_c == '0);
      end
   end

   // Storage carries no reset; stale contents are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (!rst && push_c) begin
         mem[wr_ptr] <= push_data;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && pop_c) begin
         $write("s_%0d, %0d\n", source_id, mem[rd_ptr]);
      end
   end
`endif

endmodule

// File: tb/tb_hs_fifo_source.sv
// Bench for hs_fifo_source: directed scenarios plus random traffic,
// checked against a queue-based model of the responder.
module tb_hs_fifo_source;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;
   localparam logic [DW-1:0] INIT = '0;

   logic          clk;
   logic          rst;
   logic          push_valid;
   logic          push_ready;
   logic [DW-1:0] push_data;
   logic          stall;
   logic          req;
   logic          ack;
   logic [DW-1:0] dout;
   logic [31:0]   count;
   logic [LW-1:0] level;
   logic          empty;

   hs_fifo_source #(
      .data_width    (DW),
      .depth         (DEPTH),
      .initial_value (INIT),
      .source_id     (0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .push_data  (push_data),
      .stall      (stall),
      .req        (req),
      .ack        (ack),
      .dout       (dout),
      .count      (count),
      .level      (level),
      .empty      (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of pending words plus the visible handshake state.
   logic [DW-1:0] mq [$];
   logic          m_ack;
   logic [DW-1:0] m_dout;
   int unsigned   m_count;
   logic [DW-1:0] got [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance model by the responder rules, compare.
   task automatic cycle(input logic pv, input logic [DW-1:0] pd, input logic r,
                        input logic st, input logic rs);
      logic m_pop;
      logic m_push;
      push_valid = pv;
      push_data  = pd;
      req        = r;
      stall      = st;
      rst        = rs;
      #1;
      if (!rs) chk("push_ready", 32'(push_ready), 32'(mq.size() != DEPTH));
      m_pop  = !rs && r && !m_ack && !st && (mq.size() > 0);
      m_push = !rs && pv && (mq.size() != DEPTH);
      @(posedge clk);
      if (rs) begin
         mq.delete();
         m_ack   = 1'b0;
         m_dout  = INIT;
         m_count = 0;
      end else begin
         m_ack = m_pop;
         if (m_pop) begin
            m_dout = mq.pop_front();
            m_count++;
         end
         if (m_push) mq.push_back(pd);
      end
      #1;
      chk("ack",   32'(ack),   32'(m_ack));
      chk("dout",  dout,       m_dout);
      chk("count", count,      m_count);
      chk("level", 32'(level), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      if (ack) got.push_back(dout);
   endtask

   task automatic do_reset();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic push_idle(input logic [DW-1:0] d);
      cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   // Serve until the model holds nothing and the last pulse has ended.
   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (mq.size() == 0 && !m_ack) break;
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      chk("drain_done", 32'(mq.size() == 0 && !m_ack), 32'd1);
   endtask

   task automatic chk_got(input string tag, input logic [DW-1:0] exp [$]);
      chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
   endtask

   initial begin
      logic [DW-1:0] pend [$];
      logic [DW-1:0] exp3 [$];
      int            gap;
      m_ack   = 1'b0;
      m_dout  = INIT;
      m_count = 0;

      // 1: reset then idle
      do_reset();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("t1_ack",   32'(ack),        32'd0);
      chk("t1_dout",  dout,            32'd0);
      chk("t1_count", count,           32'd0);
      chk("t1_empty", 32'(empty),      32'd1);
      chk("t1_ready", 32'(push_ready), 32'd1);

      // 2: ordered delivery with req held high
      got.delete();
      cycle(1'b1, 32'd5, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 32'd6, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 32'd7, 1'b1, 1'b0, 1'b0);
      drain();
      chk_got("t2_order", '{32'd5, 32'd6, 32'd7});
      chk("t2_count", count,      32'd3);
      chk("t2_level", 32'(level), 32'd0);

      // 3: fill to full, refuse word 5, then serve across pointer wrap
      do_reset();
      got.delete();
      for (int i = 1; i <= 5; i++) push_idle(DW'(i));
      chk("t3_level", 32'(level), 32'd4);
      chk("t3_ready", 32'(push_ready), 32'd0);
      pend = '{32'd10, 32'd11, 32'd12, 32'd13};
      for (int i = 0; i < 40 && pend.size() > 0; i++) begin
         if (mq.size() != DEPTH) begin
            cycle(1'b1, pend[0], 1'b1, 1'b0, 1'b0);
            void'(pend.pop_front());
         end else begin
            cycle(1'b1, pend[0], 1'b1, 1'b0, 1'b0);
         end
      end
      drain();
      exp3 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd11, 32'd12, 32'd13};
      chk_got("t3_order", exp3);

      // 4: stall holds off service; first ack one cycle after release
      push_idle(32'hA1);
      push_idle(32'hA2);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
         chk("t4_stall_ack",  32'(ack), 32'd0);
         chk("t4_stall_dout", dout,     32'd13);
      end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t4_release_ack",  32'(ack), 32'd1);
      chk("t4_release_dout", dout,     32'hA1);
      drain();

      // 5: push coincides with an ack edge at level 2
      got.delete();
      push_idle(32'd20);
      push_idle(32'd21);
      cycle(1'b1, 32'd30, 1'b1, 1'b0, 1'b0);
      chk("t5_level", 32'(level), 32'd2);
      chk("t5_ack",   32'(ack),   32'd1);
      drain();
      chk_got("t5_order", '{32'd20, 32'd21, 32'd30});

      // 6: reset on the edge an ack would fire
      push_idle(32'd40);
      push_idle(32'd41);
      push_idle(32'd42);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      chk("t6_ack",   32'(ack),   32'd0);
      chk("t6_level", 32'(level), 32'd0);
      chk("t6_dout",  dout,       32'd0);
      push_idle(32'd9);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t6_count", count, 32'd1);
      chk("t6_dout9", dout,  32'd9);
      drain();

      // random traffic with occasional reset
      gap = 0;
      for (int i = 0; i < 600; i++) begin
         gap = $urandom_range(0, 99);
         cycle(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) == 0), 1'(gap == 0));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
